// File: rtl/tlul_host_adapter_if.sv
// TL-UL type package plus the host/bus signal bundle for tlul_host_adapter.
// slave = adapter view; master = host-and-fabric view, used by whoever drives the adapter.
package tlul_host_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tlul_d2h_t;
endpackage

interface tlul_host_adapter_if #(
  parameter int AW = 32
) ();
  import tlul_host_pkg::*;

  // Host handshake: req_i is held with its fields until gnt_o; valid_o is a
  // one-cycle response pulse with rdata_o/err_o. TL-UL A holds a_valid until a_ready.
  logic          req_i;
  logic          gnt_o;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   wdata_i;
  logic [3:0]    be_i;
  logic          valid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  tlul_h2d_t     tl_o;
  tlul_d2h_t     tl_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, tl_i,
    output gnt_o, valid_o, rdata_o, err_o, tl_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, tl_i,
    input  gnt_o, valid_o, rdata_o, err_o, tl_o
  );
endinterface

// File: rtl/tlul_host_adapter.sv
// Host req/gnt/rsp to TL-UL host adapter with in-order source IDs and up to MaxReqs in flight.
// Optional macro TLUL_HOST_SRC_CHECK_EN: flags responses whose d_source breaks issue order.
module tlul_host_adapter
  import tlul_host_pkg::*;
#(
  parameter int MaxReqs = 2,
  parameter int AW      = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tlul_host_adapter_if.slave  bus
);

  localparam int CW = $clog2(MaxReqs + 1);
  localparam int SW = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
  localparam logic [CW-1:0] CntMax = CW'(MaxReqs);
  localparam logic [SW-1:0] SrcMax = SW'(MaxReqs - 1);

  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_src;
  logic              r_valid;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_a_valid;
  logic              w_gnt;
  logic              w_d_ack;
  logic              w_unexpected;
  logic              w_src_err;
  logic [TL_AW-1:0]  w_a_address;
  logic [TL_AIW-1:0] w_a_source;
  tlul_h2d_t         w_tl_o;

  assign w_a_valid    = bus.req_i & (r_cnt != CntMax);
  assign w_gnt        = w_a_valid & bus.tl_i.a_ready;
  assign w_d_ack      = bus.tl_i.d_valid;
  assign w_unexpected = w_d_ack & (r_cnt == '0);

  always_comb begin
    w_a_address         = '0;
    w_a_address[AW-1:0] = {bus.addr_i[AW-1:2], 2'b00};
    w_a_source          = '0;
    w_a_source[SW-1:0]  = r_src;
  end

  always_comb begin
    w_tl_o           = '0;
    w_tl_o.a_valid   = w_a_valid;
    if (!bus.we_i) begin
      w_tl_o.a_opcode = Get;
    end else if (bus.be_i == 4'hF) begin
      w_tl_o.a_opcode = PutFullData;
    end else begin
      w_tl_o.a_opcode = PutPartialData;
    end
    w_tl_o.a_param   = 3'd0;
    w_tl_o.a_size    = 2'd2;
    w_tl_o.a_source  = w_a_source;
    w_tl_o.a_address = w_a_address;
    w_tl_o.a_mask    = bus.we_i ? bus.be_i : 4'hF;
    w_tl_o.a_data    = bus.wdata_i;
    w_tl_o.d_ready   = 1'b1;
  end

  // A grant and a response in the same cycle cancel; a stray response never underflows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_src <= '0;
    end else begin
      if (w_gnt && !w_d_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_gnt && w_d_ack && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_gnt) begin
        r_src <= (r_src == SrcMax) ? '0 : r_src + 1'b1;
      end
    end
  end

`ifdef TLUL_HOST_SRC_CHECK_EN
  logic [SW-1:0]     r_rsp;
  logic [TL_AIW-1:0] w_rsp_ext;
  logic              w_unused;

  always_comb begin
    w_rsp_ext          = '0;
    w_rsp_ext[SW-1:0]  = r_rsp;
  end

  // Expected source advances on every counted response, matched or not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp <= '0;
    end else if (w_d_ack && (r_cnt != '0)) begin
      r_rsp <= (r_rsp == SrcMax) ? '0 : r_rsp + 1'b1;
    end
  end

  assign w_src_err = (bus.tl_i.d_source != w_rsp_ext);
  assign w_unused  = ^{bus.addr_i[1:0], bus.tl_i.d_param, bus.tl_i.d_size, bus.tl_i.d_sink};
`else
  logic w_unused;

  assign w_src_err = 1'b0;
  assign w_unused  = ^{bus.addr_i[1:0], bus.tl_i.d_param, bus.tl_i.d_size, bus.tl_i.d_sink,
                       bus.tl_i.d_source};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_d_ack;
      if (w_d_ack) begin
        r_rdata <= (bus.tl_i.d_opcode == AccessAckData) ? bus.tl_i.d_data : '0;
        r_err   <= bus.tl_i.d_error | w_unexpected | w_src_err;
      end
    end
  end

  assign bus.tl_o    = w_tl_o;
  assign bus.gnt_o   = w_gnt;
  assign bus.valid_o = r_valid;
  assign bus.rdata_o = r_rdata;
  assign bus.err_o   = r_err;

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter (MaxReqs = 2); expectations hand-computed per scenario.
module tb_tlul_host_adapter;
  import tlul_host_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   tests_run = 0;
  int   failed    = 0;

  tlul_host_adapter_if #(.AW(32)) bus ();

  tlul_host_adapter #(.MaxReqs(2), .AW(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

`ifdef TLUL_HOST_SRC_CHECK_EN
  localparam logic SRC_ERR_EXP = 1'b1;
`else
  localparam logic SRC_ERR_EXP = 1'b0;
`endif

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    bus.be_i    = be;
  endtask

  task automatic drive_rsp(input logic [2:0] op, input logic [31:0] data,
                           input logic err, input logic [7:0] src);
    bus.tl_i.d_valid  = 1'b1;
    bus.tl_i.d_opcode = op;
    bus.tl_i.d_data   = data;
    bus.tl_i.d_error  = err;
    bus.tl_i.d_source = src;
  endtask

  task automatic clear_rsp();
    bus.tl_i.d_valid = 1'b0;
    bus.tl_i.d_error = 1'b0;
  endtask

  task automatic drive_idle();
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.be_i    = '0;
    bus.tl_i    = '0;
    bus.tl_i.a_ready = 1'b1;
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0;
    drive_idle();
    tick();
    rst_ni = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    #12;
    tests_run++; if (bus.valid_o !== 1'b0) begin failed++; $display("FAIL rst_valid: got %0b want 0", bus.valid_o); end
    tests_run++; if (bus.rdata_o !== 32'h0) begin failed++; $display("FAIL rst_rdata: got %h want 0", bus.rdata_o); end
    tests_run++; if (bus.err_o !== 1'b0) begin failed++; $display("FAIL rst_err: got %0b want 0", bus.err_o); end
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL rst_cnt: got %0d want 0", dut.r_cnt); end
    tests_run++; if (bus.gnt_o !== 1'b0) begin failed++; $display("FAIL rst_gnt_idle: got %0b want 0", bus.gnt_o); end
    bus.req_i = 1'b1;
    #1;
    tests_run++; if (bus.gnt_o !== 1'b1) begin failed++; $display("FAIL rst_gnt_follow: got %0b want 1", bus.gnt_o); end
    tests_run++; if (bus.tl_o.a_valid !== 1'b1) begin failed++; $display("FAIL rst_avalid_follow: got %0b want 1", bus.tl_o.a_valid); end
    tests_run++; if (bus.tl_o.a_source !== 8'd0) begin failed++; $display("FAIL rst_src: got %0d want 0", bus.tl_o.a_source); end
    bus.req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    reset_dut();
    drive_req(1'b0, 32'h0000_1003, 32'h0, 4'h0);
    bus.tl_i.a_ready = 1'b0;
    #1;
    tests_run++; if (bus.tl_o.a_valid !== 1'b1) begin failed++; $display("FAIL rd_avalid_noready: got %0b want 1", bus.tl_o.a_valid); end
    tests_run++; if (bus.gnt_o !== 1'b0) begin failed++; $display("FAIL rd_gnt_noready: got %0b want 0", bus.gnt_o); end
    tick();
    bus.tl_i.a_ready = 1'b1;
    #1;
    tests_run++; if (bus.gnt_o !== 1'b1) begin failed++; $display("FAIL rd_gnt: got %0b want 1", bus.gnt_o); end
    tests_run++; if (bus.tl_o.a_opcode !== Get) begin failed++; $display("FAIL rd_opcode: got %0d want 4", bus.tl_o.a_opcode); end
    tests_run++; if (bus.tl_o.a_address !== 32'h0000_1000) begin failed++; $display("FAIL rd_addr: got %h want 00001000", bus.tl_o.a_address); end
    tests_run++; if (bus.tl_o.a_mask !== 4'hF) begin failed++; $display("FAIL rd_mask: got %h want f", bus.tl_o.a_mask); end
    tests_run++; if (bus.tl_o.a_source !== 8'd0) begin failed++; $display("FAIL rd_src: got %0d want 0", bus.tl_o.a_source); end
    tests_run++; if (bus.tl_o.a_size !== 2'd2) begin failed++; $display("FAIL rd_size: got %0d want 2", bus.tl_o.a_size); end
    tests_run++; if (bus.tl_o.d_ready !== 1'b1) begin failed++; $display("FAIL rd_dready: got %0b want 1", bus.tl_o.d_ready); end
    tick();
    bus.req_i = 1'b0;
    drive_rsp(AccessAckData, 32'hDEAD_BEEF, 1'b0, 8'd0);
    tick();
    clear_rsp();
    tests_run++; if (bus.valid_o !== 1'b1) begin failed++; $display("FAIL rd_valid: got %0b want 1", bus.valid_o); end
    tests_run++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin failed++; $display("FAIL rd_rdata: got %h want deadbeef", bus.rdata_o); end
    tests_run++; if (bus.err_o !== 1'b0) begin failed++; $display("FAIL rd_err: got %0b want 0", bus.err_o); end
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL rd_cnt: got %0d want 0", dut.r_cnt); end
    tick();
    tests_run++; if (bus.valid_o !== 1'b0) begin failed++; $display("FAIL rd_valid_pulse: got %0b want 0", bus.valid_o); end
  endtask

  task automatic test_writes();
    reset_dut();
    drive_req(1'b1, 32'h0000_2004, 32'h1234_5678, 4'hF);
    #1;
    tests_run++; if (bus.tl_o.a_opcode !== PutFullData) begin failed++; $display("FAIL wr_full_opcode: got %0d want 0", bus.tl_o.a_opcode); end
    tests_run++; if (bus.tl_o.a_mask !== 4'hF) begin failed++; $display("FAIL wr_full_mask: got %h want f", bus.tl_o.a_mask); end
    tests_run++; if (bus.tl_o.a_data !== 32'h1234_5678) begin failed++; $display("FAIL wr_full_data: got %h want 12345678", bus.tl_o.a_data); end
    tests_run++; if (bus.tl_o.a_address !== 32'h0000_2004) begin failed++; $display("FAIL wr_full_addr: got %h want 00002004", bus.tl_o.a_address); end
    tick();
    drive_req(1'b1, 32'h0000_2008, 32'hA5A5_0000, 4'h3);
    #1;
    tests_run++; if (bus.tl_o.a_opcode !== PutPartialData) begin failed++; $display("FAIL wr_part_opcode: got %0d want 1", bus.tl_o.a_opcode); end
    tests_run++; if (bus.tl_o.a_mask !== 4'h3) begin failed++; $display("FAIL wr_part_mask: got %h want 3", bus.tl_o.a_mask); end
    tests_run++; if (bus.tl_o.a_source !== 8'd1) begin failed++; $display("FAIL wr_part_src: got %0d want 1", bus.tl_o.a_source); end
    tests_run++; if (bus.gnt_o !== 1'b1) begin failed++; $display("FAIL wr_part_gnt: got %0b want 1", bus.gnt_o); end
    tick();
    bus.req_i = 1'b0;
    drive_rsp(AccessAck, 32'hFFFF_FFFF, 1'b1, 8'd0);
    tick();
    drive_rsp(AccessAck, 32'h0BAD_F00D, 1'b0, 8'd1);
    tests_run++; if (bus.valid_o !== 1'b1) begin failed++; $display("FAIL wr_rsp1_valid: got %0b want 1", bus.valid_o); end
    tests_run++; if (bus.err_o !== 1'b1) begin failed++; $display("FAIL wr_rsp1_err: got %0b want 1", bus.err_o); end
    tests_run++; if (bus.rdata_o !== 32'h0) begin failed++; $display("FAIL wr_rsp1_rdata: got %h want 0", bus.rdata_o); end
    tick();
    clear_rsp();
    tests_run++; if (bus.valid_o !== 1'b1) begin failed++; $display("FAIL wr_rsp2_valid: got %0b want 1", bus.valid_o); end
    tests_run++; if (bus.err_o !== 1'b0) begin failed++; $display("FAIL wr_rsp2_err: got %0b want 0", bus.err_o); end
    tests_run++; if (bus.rdata_o !== 32'h0) begin failed++; $display("FAIL wr_rsp2_rdata: got %h want 0", bus.rdata_o); end
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL wr_cnt: got %0d want 0", dut.r_cnt); end
  endtask

  task automatic test_full_stall();
    reset_dut();
    drive_req(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    #1;
    tests_run++; if (bus.gnt_o !== 1'b1) begin failed++; $display("FAIL full_gnt0: got %0b want 1", bus.gnt_o); end
    tests_run++; if (bus.tl_o.a_source !== 8'd0) begin failed++; $display("FAIL full_src0: got %0d want 0", bus.tl_o.a_source); end
    tick();
    tests_run++; if (bus.gnt_o !== 1'b1) begin failed++; $display("FAIL full_gnt1: got %0b want 1", bus.gnt_o); end
    tests_run++; if (bus.tl_o.a_source !== 8'd1) begin failed++; $display("FAIL full_src1: got %0d want 1", bus.tl_o.a_source); end
    tick();
    tests_run++; if (bus.tl_o.a_valid !== 1'b0) begin failed++; $display("FAIL full_avalid: got %0b want 0", bus.tl_o.a_valid); end
    tests_run++; if (bus.gnt_o !== 1'b0) begin failed++; $display("FAIL full_gnt: got %0b want 0", bus.gnt_o); end
    tests_run++; if (dut.r_cnt !== 2'd2) begin failed++; $display("FAIL full_cnt: got %0d want 2", dut.r_cnt); end
    drive_rsp(AccessAckData, 32'h0000_0011, 1'b0, 8'd0);
    #1;
    tests_run++; if (bus.gnt_o !== 1'b0) begin failed++; $display("FAIL full_gnt_rsp: got %0b want 0", bus.gnt_o); end
    tick();
    clear_rsp();
    #1;
    tests_run++; if (bus.valid_o !== 1'b1) begin failed++; $display("FAIL full_rsp_valid: got %0b want 1", bus.valid_o); end
    tests_run++; if (bus.rdata_o !== 32'h0000_0011) begin failed++; $display("FAIL full_rsp_rdata: got %h want 00000011", bus.rdata_o); end
    tests_run++; if (bus.gnt_o !== 1'b1) begin failed++; $display("FAIL full_resume_gnt: got %0b want 1", bus.gnt_o); end
    tests_run++; if (bus.tl_o.a_source !== 8'd0) begin failed++; $display("FAIL full_resume_src: got %0d want 0", bus.tl_o.a_source); end
    tick();
    bus.req_i = 1'b0;
    tests_run++; if (dut.r_cnt !== 2'd2) begin failed++; $display("FAIL full_refill_cnt: got %0d want 2", dut.r_cnt); end
    drive_rsp(AccessAck, 32'h0, 1'b0, 8'd1);
    tick();
    drive_rsp(AccessAck, 32'h0, 1'b0, 8'd0);
    tests_run++; if (bus.err_o !== 1'b0) begin failed++; $display("FAIL full_drain1_err: got %0b want 0", bus.err_o); end
    tick();
    clear_rsp();
    tests_run++; if (bus.err_o !== 1'b0) begin failed++; $display("FAIL full_drain2_err: got %0b want 0", bus.err_o); end
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL full_drain_cnt: got %0d want 0", dut.r_cnt); end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    drive_req(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    tick();
    drive_rsp(AccessAck, 32'h0, 1'b0, 8'd0);
    #1;
    tests_run++; if (bus.gnt_o !== 1'b1) begin failed++; $display("FAIL sim_gnt: got %0b want 1", bus.gnt_o); end
    tick();
    bus.req_i = 1'b0;
    clear_rsp();
    tests_run++; if (dut.r_cnt !== 2'd1) begin failed++; $display("FAIL sim_cnt: got %0d want 1", dut.r_cnt); end
    tests_run++; if (bus.valid_o !== 1'b1) begin failed++; $display("FAIL sim_valid: got %0b want 1", bus.valid_o); end
    tests_run++; if (bus.err_o !== 1'b0) begin failed++; $display("FAIL sim_err: got %0b want 0", bus.err_o); end
    drive_rsp(AccessAck, 32'h0, 1'b0, 8'd1);
    tick();
    clear_rsp();
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL sim_drain_cnt: got %0d want 0", dut.r_cnt); end
    tests_run++; if (bus.err_o !== 1'b0) begin failed++; $display("FAIL sim_drain_err: got %0b want 0", bus.err_o); end
    drive_rsp(AccessAckData, 32'h0000_0077, 1'b0, 8'd0);
    tick();
    clear_rsp();
    tests_run++; if (bus.valid_o !== 1'b1) begin failed++; $display("FAIL unexp_valid: got %0b want 1", bus.valid_o); end
    tests_run++; if (bus.err_o !== 1'b1) begin failed++; $display("FAIL unexp_err: got %0b want 1", bus.err_o); end
    tests_run++; if (bus.rdata_o !== 32'h0000_0077) begin failed++; $display("FAIL unexp_rdata: got %h want 00000077", bus.rdata_o); end
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL unexp_cnt: got %0d want 0", dut.r_cnt); end
    drive_req(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    drive_rsp(AccessAck, 32'h0, 1'b0, 8'd0);
    #1;
    tests_run++; if (bus.gnt_o !== 1'b1) begin failed++; $display("FAIL empty_gnt: got %0b want 1", bus.gnt_o); end
    tick();
    bus.req_i = 1'b0;
    clear_rsp();
    tests_run++; if (bus.err_o !== 1'b1) begin failed++; $display("FAIL empty_unexp_err: got %0b want 1", bus.err_o); end
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL empty_cnt: got %0d want 0", dut.r_cnt); end
  endtask

  task automatic test_src_order();
    reset_dut();
    drive_req(1'b0, 32'h0000_0300, 32'h0, 4'hF);
    tick();
    tick();
    bus.req_i = 1'b0;
    drive_rsp(AccessAck, 32'h0, 1'b0, 8'd1);
    tick();
    drive_rsp(AccessAck, 32'h0, 1'b0, 8'd0);
    tests_run++; if (bus.err_o !== SRC_ERR_EXP) begin failed++; $display("FAIL src_rsp1_err: got %0b want %0b", bus.err_o, SRC_ERR_EXP); end
    tick();
    clear_rsp();
    tests_run++; if (bus.err_o !== SRC_ERR_EXP) begin failed++; $display("FAIL src_rsp2_err: got %0b want %0b", bus.err_o, SRC_ERR_EXP); end
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL src_cnt: got %0d want 0", dut.r_cnt); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    drive_req(1'b1, 32'h0000_0400, 32'h5555_AAAA, 4'hF);
    tick();
    tick();
    bus.req_i = 1'b0;
    tests_run++; if (dut.r_cnt !== 2'd2) begin failed++; $display("FAIL mid_cnt_pre: got %0d want 2", dut.r_cnt); end
    #2;
    rst_ni = 1'b0;
    #1;
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL mid_cnt_clr: got %0d want 0", dut.r_cnt); end
    bus.req_i = 1'b1;
    #1;
    tests_run++; if (bus.tl_o.a_source !== 8'd0) begin failed++; $display("FAIL mid_src_clr: got %0d want 0", bus.tl_o.a_source); end
    bus.req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    drive_rsp(AccessAckData, 32'h0000_CAFE, 1'b0, 8'd0);
    tick();
    clear_rsp();
    tests_run++; if (bus.valid_o !== 1'b1) begin failed++; $display("FAIL late_valid: got %0b want 1", bus.valid_o); end
    tests_run++; if (bus.err_o !== 1'b1) begin failed++; $display("FAIL late_err: got %0b want 1", bus.err_o); end
    tests_run++; if (dut.r_cnt !== 2'd0) begin failed++; $display("FAIL late_cnt: got %0d want 0", dut.r_cnt); end
    rst_ni = 1'b0;
    #1;
    tests_run++; if (bus.valid_o !== 1'b0) begin failed++; $display("FAIL mid_valid_drop: got %0b want 0", bus.valid_o); end
    tests_run++; if (bus.err_o !== 1'b0) begin failed++; $display("FAIL mid_err_drop: got %0b want 0", bus.err_o); end
    tests_run++; if (bus.rdata_o !== 32'h0) begin failed++; $display("FAIL mid_rdata_drop: got %h want 0", bus.rdata_o); end
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_writes();
    test_full_stall();
    test_simultaneous();
    test_src_order();
    test_reset_mid();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
